// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Front-end conditioner for the stopwatch push-buttons (start, stop, split).
//   Each raw asynchronous button is brought into the clk domain through a 2-FF
//   synchronizer and then filtered by its own counter-based debounce FSM.
//   Every channel produces a clean level, one-cycle rise/fall pulses and a
//   one-cycle long-press (hold) pulse. All outputs are registered.
//
// Parameters
//   N_BTN       number of independent button channels
//   DB_CYCLES   debounce window in clk cycles (>= 2)
//   HOLD_CYCLES stable-pressed time before the hold pulse (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_in     raw asynchronous button levels, 1 = pressed
//   btn_level  debounced level per channel
//   rise       one-cycle pulse on debounced press
//   fall       one-cycle pulse on debounced release
//   hold       one-cycle pulse once per press after HOLD_CYCLES held
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall,
  output logic [N_BTN-1:0] hold
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  // One extra bit so the counter can saturate at HOLD_CYCLES itself.
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;

  // Two-stage synchronizer for the raw asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DB_W-1:0]     db_cnt_r;
    logic [DB_W-1:0]     db_cnt_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_nxt_s;
    logic                level_r;
    logic                rise_r;
    logic                fall_r;
    logic                hold_r;
    logic                level_nxt_s;
    logic                rise_nxt_s;
    logic                fall_nxt_s;
    logic                hold_nxt_s;
    logic                in_s;
    logic                db_last_s;

    assign in_s      = sync2_r[g];
    assign db_last_s = (db_cnt_r == DB_LAST);

    // State, counter and output registers for this channel.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r    <= IDLE;
        db_cnt_r   <= '0;
        hold_cnt_r <= '0;
        level_r    <= 1'b0;
        rise_r     <= 1'b0;
        fall_r     <= 1'b0;
        hold_r     <= 1'b0;
      end else begin
        state_r    <= state_nxt_s;
        db_cnt_r   <= db_cnt_nxt_s;
        hold_cnt_r <= hold_cnt_nxt_s;
        level_r    <= level_nxt_s;
        rise_r     <= rise_nxt_s;
        fall_r     <= fall_nxt_s;
        hold_r     <= hold_nxt_s;
      end
    end

    // Next-state and counter update for the debounce FSM.
    always_comb begin
      state_nxt_s    = state_r;
      db_cnt_nxt_s   = db_cnt_r;
      hold_cnt_nxt_s = hold_cnt_r;
      case (state_r)
        IDLE: begin
          if (in_s) begin
            state_nxt_s  = PRESS_WAIT;
            db_cnt_nxt_s = '0;
          end else begin
            state_nxt_s  = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!in_s) begin
            // Bounce: drop back without any pulse.
            state_nxt_s    = IDLE;
          end else if (db_last_s) begin
            state_nxt_s    = PRESSED;
            hold_cnt_nxt_s = '0;
          end else begin
            db_cnt_nxt_s   = db_cnt_r + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!in_s) begin
            // hold_cnt is left untouched so a release glitch resumes it.
            state_nxt_s    = RELEASE_WAIT;
            db_cnt_nxt_s   = '0;
          end else if (hold_cnt_r < HOLD_MAX) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
          end else begin
            // Saturated: hold already fired for this press.
            hold_cnt_nxt_s = hold_cnt_r;
          end
        end
        RELEASE_WAIT: begin
          if (in_s) begin
            state_nxt_s  = PRESSED;
          end else if (db_last_s) begin
            state_nxt_s  = IDLE;
          end else begin
            db_cnt_nxt_s = db_cnt_r + DB_W'(1);
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          db_cnt_nxt_s   = '0;
          hold_cnt_nxt_s = '0;
        end
      endcase
    end

    // Next values of the registered level and pulse outputs.
    always_comb begin
      level_nxt_s = 1'b0;
      rise_nxt_s  = 1'b0;
      fall_nxt_s  = 1'b0;
      hold_nxt_s  = 1'b0;
      case (state_r)
        IDLE: begin
          level_nxt_s = 1'b0;
        end
        PRESS_WAIT: begin
          if (in_s && db_last_s) begin
            rise_nxt_s  = 1'b1;
            level_nxt_s = 1'b1;
          end else begin
            level_nxt_s = 1'b0;
          end
        end
        PRESSED: begin
          level_nxt_s = 1'b1;
          if (in_s && (hold_cnt_r == HOLD_LAST)) begin
            hold_nxt_s = 1'b1;
          end else begin
            hold_nxt_s = 1'b0;
          end
        end
        RELEASE_WAIT: begin
          if (!in_s && db_last_s) begin
            fall_nxt_s  = 1'b1;
            level_nxt_s = 1'b0;
          end else begin
            level_nxt_s = 1'b1;
          end
        end
        default: begin
          level_nxt_s = 1'b0;
        end
      endcase
    end

    assign btn_level[g] = level_r;
    assign rise[g]      = rise_r;
    assign fall[g]      = fall_r;
    assign hold[g]      = hold_r;

  end : g_ch

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed-vector bench for btn_conditioner with DB_CYCLES=4, HOLD_CYCLES=20,
//   N_BTN=3. Edge 0 is the first clk edge that samples a new btn_in value.
//   Every comparison checks the packed vector {rise, fall, hold, btn_level}.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int N_BTN = 3;
  localparam int DB    = 4;
  localparam int HOLD  = 20;

  logic             clk;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] hold;

  int vec_cnt = 0;
  int err_cnt = 0;

  btn_conditioner #(
    .N_BTN      (N_BTN),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .rise     (rise),
    .fall     (fall),
    .hold     (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] mk(input logic [2:0] r, input logic [2:0] f,
                                     input logic [2:0] h, input logic [2:0] l);
    return {r, f, h, l};
  endfunction

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check_vec(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %03h (r/f/h/l) expected %03h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {rise, fall, hold, btn_level};
  endfunction

  initial begin
    rst    = 1'b1;
    btn_in = 3'b000;
    tick();
    tick();
    check_vec("reset", outs(), 12'h000);
    rst = 1'b0;

    // Clean press on ch0: rise after edge 6, hold after edge 26.
    btn_in = 3'b001;
    for (int e = 0; e < 40; e++) begin
      tick();
      check_vec($sformatf("press e%0d", e), outs(),
                mk((e == 6) ? 3'b001 : 3'b000, 3'b000,
                   (e == 26) ? 3'b001 : 3'b000,
                   (e >= 6) ? 3'b001 : 3'b000));
    end

    // Release glitch: two low samples, then high again; nothing changes.
    btn_in = 3'b000;
    for (int e = 0; e < 12; e++) begin
      if (e == 2) btn_in = 3'b001;
      tick();
      check_vec($sformatf("glitch e%0d", e), outs(), mk(3'b000, 3'b000, 3'b000, 3'b001));
    end

    // Clean release on ch0: fall after edge 6.
    btn_in = 3'b000;
    for (int e = 0; e < 12; e++) begin
      tick();
      check_vec($sformatf("release e%0d", e), outs(),
                mk(3'b000, (e == 6) ? 3'b001 : 3'b000, 3'b000,
                   (e < 6) ? 3'b001 : 3'b000));
    end

    // Bounce on ch1: 1,0,1,0 every two cycles, then steady 0.
    for (int k = 0; k < 4; k++) begin
      btn_in = ((k % 2) == 0) ? 3'b010 : 3'b000;
      for (int j = 0; j < 2; j++) begin
        tick();
        check_vec($sformatf("bounce k%0d j%0d", k, j), outs(), 12'h000);
      end
    end
    btn_in = 3'b000;
    for (int e = 0; e < 10; e++) begin
      tick();
      check_vec($sformatf("bounce tail e%0d", e), outs(), 12'h000);
    end

    // Simultaneous press on ch0 and ch2, run ch2 up to hold_cnt=10.
    btn_in = 3'b101;
    for (int e = 0; e < 17; e++) begin
      tick();
      check_vec($sformatf("simul e%0d", e), outs(),
                mk((e == 6) ? 3'b101 : 3'b000, 3'b000, 3'b000,
                   (e >= 6) ? 3'b101 : 3'b000));
    end

    // One-cycle reset mid-hold; ch2 stays pressed, ch0 released.
    rst    = 1'b1;
    btn_in = 3'b100;
    tick();
    check_vec("rst mid-hold", outs(), 12'h000);
    rst = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      check_vec($sformatf("post-rst e%0d", e), outs(),
                mk((e == 6) ? 3'b100 : 3'b000, 3'b000,
                   (e == 26) ? 3'b100 : 3'b000,
                   (e >= 6) ? 3'b100 : 3'b000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
